// File: rtl/dual_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_ram_pkg
// Brief    : Shared types and constants for the dual_ram_clear block: FSM
//            state enum, same-address collision mode encodings, read latency
//            limits and a byte parity helper.
// Revision : 1.0 - initial release
// ============================================================================
package dual_ram_pkg;

    // Sweep state: CLEAR zeroes the array, IDLE services reads/writes
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Same-cycle read/write to one address
    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;

    // Supported read latency range in cycles
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    // Even parity bit of one byte (stored bit makes the 9-bit lane XOR to 0)
    function automatic logic parity8(input logic [7:0] b);
        return ^b;
    endfunction

endpackage : dual_ram_pkg
`default_nettype wire

// File: rtl/dual_ram_array.sv
`default_nettype none
// ============================================================================
// Module   : dual_ram_array
// Brief    : Simple dual-port storage, one write and one read port, lane
//            write enables, registered read output and no reset so that
//            synthesis can map it onto block RAM.
// Revision : 1.0 - initial release
// ============================================================================
module dual_ram_array #(
    parameter int LANES  = 2,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic                    clk,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [LANES*LANE_W-1:0] wr_data_i,
    input  logic [LANES-1:0]        wr_lane_i,
    input  logic                    rd_en_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic [LANES*LANE_W-1:0] rd_data_o
);

    logic [LANES*LANE_W-1:0] mem_q [DEPTH];
    logic [LANES*LANE_W-1:0] rd_data_q;

    // Lane-masked write and read-before-write registered read
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane_i[i]) begin
                    mem_q[wr_addr_i][i*LANE_W +: LANE_W] <= wr_data_i[i*LANE_W +: LANE_W];
                end
            end
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : dual_ram_array
`default_nettype wire

// File: rtl/dual_ram_clear.sv
`default_nettype none
// ============================================================================
// Module   : dual_ram_clear
// Brief    : Byte-enabled dual-port RAM with a full-array zero sweep after
//            reset or on request, optional write-first collision bypass and
//            a 1- or 2-cycle read latency.
//            Define DUAL_RAM_PARITY_EN to store one even-parity bit per byte
//            and flag mismatches on parity_err_o; otherwise parity_err_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module dual_ram_clear
    import dual_ram_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int READ_LAT   = 1,
    parameter int WRITE_MODE = WM_READ_FIRST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_req_i,
    output logic                     busy_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [WIDTH/8-1:0]       wr_be_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic                     parity_err_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int BYTES = WIDTH / 8;
`ifdef DUAL_RAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int WORD_W = BYTES * LANE_W;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                rd_acc, wr_acc;

    logic                arr_we, arr_re;
    logic [AW-1:0]       arr_waddr;
    logic [BYTES-1:0]    arr_lane;
    logic [WORD_W-1:0]   arr_wword, wr_word, arr_rdata;

    logic [WIDTH-1:0]    raw_data, m1_data;
    logic [BYTES-1:0]    lane_err;
    logic                m1_perr;

    logic                rv1_q, hit1_q;
    logic [BYTES-1:0]    be1_q;
    logic [WIDTH-1:0]    wd1_q;

    // State and sweep counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep every address once, re-enter CLEAR only from IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_o  = (state_q == ST_CLEAR);
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // User accesses are only honoured outside the sweep
    assign rd_acc = (state_q == ST_IDLE) && rd_en_i;
    assign wr_acc = (state_q == ST_IDLE) && wr_en_i;

    // Array port steering: the sweep owns the write port while clearing
    always_comb begin
        arr_we    = wr_acc;
        arr_waddr = wr_addr_i;
        arr_lane  = wr_be_i;
        arr_wword = wr_word;
        arr_re    = rd_acc;
        if (state_q == ST_CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = cnt_q;
            arr_lane  = '1;
            arr_wword = '0;
        end
    end

    dual_ram_array #(
        .LANES  (BYTES),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (arr_we),
        .wr_addr_i (arr_waddr),
        .wr_data_i (arr_wword),
        .wr_lane_i (arr_lane),
        .rd_en_i   (arr_re),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (arr_rdata)
    );

    // First read stage: valid strobe plus the write that collided with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1_q  <= 1'b0;
            hit1_q <= 1'b0;
            be1_q  <= '0;
            wd1_q  <= '0;
        end else begin
            rv1_q  <= rd_acc;
            hit1_q <= rd_acc && wr_acc && (wr_addr_i == rd_addr_i) &&
                      (WRITE_MODE == WM_WRITE_FIRST);
            be1_q  <= wr_be_i;
            wd1_q  <= wr_data_i;
        end
    end

    // Per byte lane: pack parity on write, unpack/bypass/check on read
    for (genvar g = 0; g < BYTES; g++) begin : g_lane
        logic byp;
        assign byp = hit1_q & be1_q[g];
        assign m1_data[8*g +: 8] = byp ? wd1_q[8*g +: 8] : raw_data[8*g +: 8];
`ifdef DUAL_RAM_PARITY_EN
        assign wr_word[g*LANE_W +: LANE_W] = {parity8(wr_data_i[8*g +: 8]), wr_data_i[8*g +: 8]};
        assign raw_data[8*g +: 8]          = arr_rdata[g*LANE_W +: 8];
        assign lane_err[g] = ~byp & (arr_rdata[g*LANE_W + 8] ^ parity8(arr_rdata[g*LANE_W +: 8]));
`else
        assign wr_word[g*LANE_W +: LANE_W] = wr_data_i[8*g +: 8];
        assign raw_data[8*g +: 8]          = arr_rdata[g*LANE_W +: LANE_W];
        assign lane_err[g]                 = 1'b0;
`endif
    end

    assign m1_perr = |lane_err;

    if (READ_LAT == READ_LAT_MAX) begin : g_lat2
        logic             rv2_q, pe2_q;
        logic [WIDTH-1:0] rd2_q;

        // Second read stage; data held at zero when no read completes
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv2_q <= 1'b0;
                pe2_q <= 1'b0;
                rd2_q <= '0;
            end else begin
                rv2_q <= rv1_q;
                pe2_q <= rv1_q & m1_perr;
                rd2_q <= rv1_q ? m1_data : '0;
            end
        end

        assign rd_valid_o   = rv2_q;
        assign rd_data_o    = rd2_q;
        assign parity_err_o = pe2_q;
    end else begin : g_lat1
        assign rd_valid_o   = rv1_q;
        assign rd_data_o    = rv1_q ? m1_data : '0;
        assign parity_err_o = rv1_q & m1_perr;
    end

endmodule : dual_ram_clear
`default_nettype wire

// File: tb/tb_dual_ram_clear.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_ram_clear
// Brief    : Scoreboard bench for dual_ram_clear. Two instances share the
//            stimulus: (READ_LAT=1, read-first) and (READ_LAT=2, write-first).
//            A reference memory model predicts every read; a monitor pops
//            and compares whenever an instance raises rd_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_ram_clear;

    localparam int WIDTH = 16;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int BYTES = WIDTH / 8;
    localparam int N_DUT = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             perr;
        int               cyc;
    } exp_t;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 clear_req = 1'b0;
    logic                 wr_en     = 1'b0;
    logic [AW-1:0]        wr_addr   = '0;
    logic [WIDTH-1:0]     wr_data   = '0;
    logic [BYTES-1:0]     wr_be     = '0;
    logic                 rd_en     = 1'b0;
    logic [AW-1:0]        rd_addr   = '0;

    logic [N_DUT-1:0]             busy, rd_valid, perr;
    logic [N_DUT-1:0][WIDTH-1:0]  rd_data;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   sweep_left = 0;

    exp_t             sbq   [N_DUT][$];
    logic [WIDTH-1:0] mem_m [DEPTH];
    logic [BYTES-1:0] bad_m [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < N_DUT; k++) begin : g_dut
        dual_ram_clear #(
            .WIDTH      (WIDTH),
            .DEPTH      (DEPTH),
            .READ_LAT   (k + 1),
            .WRITE_MODE (k)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear_req_i  (clear_req),
            .busy_o       (busy[k]),
            .wr_en_i      (wr_en),
            .wr_addr_i    (wr_addr),
            .wr_data_i    (wr_data),
            .wr_be_i      (wr_be),
            .rd_en_i      (rd_en),
            .rd_addr_i    (rd_addr),
            .rd_data_o    (rd_data[k]),
            .rd_valid_o   (rd_valid[k]),
            .parity_err_o (perr[k])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                               input logic [WIDTH-1:0] d,
                                               input logic [BYTES-1:0] be);
        logic [WIDTH-1:0] r;
        r = old;
        for (int b = 0; b < BYTES; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic wipe();
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = '0;
            bad_m[a] = '0;
        end
    endtask

    task automatic chk_reset();
        for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("reset_busy dut%0d", k), busy[k], 1);
            chk($sformatf("reset_rd_valid dut%0d", k), rd_valid[k], 0);
            chk($sformatf("reset_rd_data dut%0d", k), rd_data[k], 0);
            chk($sformatf("reset_parity_err dut%0d", k), perr[k], 0);
        end
    endtask

    // One clock of stimulus, issued at a negedge; the model decides what the
    // block should do with it and queues the predicted read responses.
    task automatic drive(input logic clr, input logic we, input logic [AW-1:0] wa,
                         input logic [WIDTH-1:0] wd, input logic [BYTES-1:0] be,
                         input logic re, input logic [AW-1:0] ra);
        logic [WIDTH-1:0] nw;
        logic             hit;
        exp_t             e;
        for (int k = 0; k < N_DUT; k++)
            chk($sformatf("busy dut%0d cyc=%0d", k, cyc), busy[k], (sweep_left > 0));
        clear_req = clr;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        wr_be     = be;
        rd_en     = re;
        rd_addr   = ra;
        if (sweep_left > 0) begin
            sweep_left--;
        end else begin
            nw  = merge(mem_m[wa], wd, be);
            hit = we && (wa == ra);
            if (re) begin
                for (int k = 0; k < N_DUT; k++) begin
                    e.data = (k == 1 && hit) ? nw : mem_m[ra];
                    e.perr = |(bad_m[ra] & ~((k == 1 && hit) ? be : '0));
                    e.cyc  = cyc + 1 + k;
                    sbq[k].push_back(e);
                end
            end
            if (we) begin
                mem_m[wa] = nw;
                bad_m[wa] = bad_m[wa] & ~be;
            end
            if (clr) begin
                sweep_left = DEPTH;
                wipe();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [BYTES-1:0] be);
        drive(1'b0, 1'b1, a, d, be, 1'b0, '0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < N_DUT; k++) begin
            if (rd_valid[k]) begin
                if (sbq[k].size() == 0) begin
                    chk($sformatf("spurious_rd_valid dut%0d cyc=%0d", k, cyc), rd_valid[k], 0);
                end else begin
                    e = sbq[k].pop_front();
                    chk($sformatf("rd_cycle dut%0d", k), cyc, e.cyc);
                    chk($sformatf("rd_data dut%0d cyc=%0d", k, cyc), rd_data[k], e.data);
                    chk($sformatf("parity_err dut%0d cyc=%0d", k, cyc), perr[k], e.perr);
                end
            end else begin
                if (perr[k]) chk($sformatf("parity_err_idle dut%0d", k), perr[k], 0);
                if (sbq[k].size() != 0 && sbq[k][0].cyc < cyc) begin
                    e = sbq[k].pop_front();
                    chk($sformatf("missing_rd_valid dut%0d due=%0d", k, e.cyc), rd_valid[k], 1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt [N_DUT];
        wipe();
        repeat (3) @(negedge clk);
        chk_reset();

        // Post-reset sweep length
        for (int k = 0; k < N_DUT; k++) busy_cnt[k] = 0;
        rst_n = 1'b1;
        for (int t = 0; t < DEPTH + 20; t++) begin
            for (int k = 0; k < N_DUT; k++) busy_cnt[k] += int'(busy[k]);
            @(negedge clk);
        end
        for (int k = 0; k < N_DUT; k++)
            chk($sformatf("busy_len dut%0d", k), busy_cnt[k], DEPTH);
        sweep_left = 0;

        // Directed cases
        rd(8'hFF);
        wr(8'd5, 16'h1234, 2'b11);
        wr(8'd5, 16'hABCD, 2'b01);
        rd(8'd5);
        drive(1'b0, 1'b1, 8'd5, 16'hFFFF, 2'b00, 1'b1, 8'd5);
        rd(8'd5);
        wr(8'd9, 16'h1111, 2'b11);
        drive(1'b0, 1'b1, 8'd9, 16'hBEEF, 2'b11, 1'b1, 8'd9);
        rd(8'd9);
        wr(8'd1, 16'h0101, 2'b11);
        wr(8'd2, 16'h0202, 2'b11);
        wr(8'd3, 16'h0303, 2'b11);
        rd(8'd1);
        rd(8'd2);
        rd(8'd3);
        drive(1'b0, 1'b1, 8'd4, 16'hA5C3, 2'b10, 1'b1, 8'd4);
        repeat (4) idle();

        // Randomised traffic on a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 127) == 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), WIDTH'($urandom),
                  BYTES'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)));
        end
        while (sweep_left > 0) idle();
        repeat (3) idle();

        // Clear request with in-flight read, dropped write, ignored re-request
        wr(8'd7, 16'h7777, 2'b11);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b1, 8'd7);
        for (int t = 0; t < DEPTH; t++)
            drive(1'(t == 20), 1'(t == 10), 8'd20, 16'hDEAD, 2'b11, 1'(t == 30), 8'd7);
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));
        repeat (4) idle();

`ifdef DUAL_RAM_PARITY_EN
        // Corrupt the low-byte parity bit at address 3 in both instances
        wr(8'd3, 16'h5A5A, 2'b11);
        idle();
        g_dut[0].u_dut.u_array.mem_q[3][8] = ~g_dut[0].u_dut.u_array.mem_q[3][8];
        g_dut[1].u_dut.u_array.mem_q[3][8] = ~g_dut[1].u_dut.u_array.mem_q[3][8];
        bad_m[3] = 2'b01;
        rd(8'd3);
        rd(8'd2);
        repeat (3) idle();
`else
        wr(8'd3, 16'h5A5A, 2'b11);
        rd(8'd3);
        repeat (3) idle();
`endif

        // Reset while a read is in flight: the read must vanish
        clear_req = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = 8'd5;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        chk_reset();
        for (int k = 0; k < N_DUT; k++) sbq[k].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wipe();
        sweep_left = DEPTH;

        // Reset mid-sweep: sweep must restart at full length
        repeat (100) idle();
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wipe();
        sweep_left = DEPTH;
        while (sweep_left > 0) idle();
        rd(8'd5);
        rd(8'hFF);
        repeat (4) idle();

        for (int k = 0; k < N_DUT; k++)
            chk($sformatf("scoreboard_empty dut%0d", k), sbq[k].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_dual_ram_clear
`default_nettype wire
